pic_bus_control: RTL and testbench
==================================

PIC_BUS_CONTROL -- requirements
Module: pic_bus_control

Interface
REQ-001 clk  input  1  system clock; all state changes on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 chip_select_n  input  1  CPU chip select, active low.
REQ-004 read_enable_n  input  1  CPU read strobe, active low.
REQ-005 write_enable_n  input  1  CPU write strobe, active low.
REQ-006 address  input  1  CPU A0.
REQ-007 data_bus_in  input  8  CPU write data.
REQ-008 internal_data_bus  output  8  latched write data for the control logic.
REQ-009 write_ICW_1, write_ICW_2_4, write_OCW_1, write_OCW_2, write_OCW_3  output  1 each  one-cycle command strobes.
REQ-010 read  output  1  registered read-access level.
REQ-011 read_address  output  1  A0 of the current read access.
REQ-012 init_done  output  1  high when the ICW sequence is complete.

Function
REQ-013 Each clk edge registers wr_act = ~chip_select_n & ~write_enable_n and rd_act = ~chip_select_n & ~read_enable_n.
REQ-014 While sampled wr_act=1, data_bus_in and address are captured every cycle; the last captured values are used.
REQ-015 A write completes at the first edge where sampled wr_act goes 1->0, whether CS or WR deasserted.
REQ-016 Write completion latency: the strobe goes high 2 clk edges after WR_n/CS_n rises and stays high exactly 1 cycle.
REQ-017 At most one strobe is high in any cycle.
REQ-018 internal_data_bus updates to the captured data in the same cycle as the strobe and holds until the next completed write.
REQ-019 ICW state machine states: WAIT_ICW1, ICW2, ICW3, ICW4, READY.
REQ-020 A write with A0=0, D4=1 in any state gives write_ICW_1, latches SNGL=D1 and IC4=D0, and moves to ICW2.
REQ-021 A write with A0=1 in ICW2 gives write_ICW_2_4, then moves to ICW3 if SNGL=0, else to ICW4 if IC4=1, else to READY.
REQ-022 A write with A0=1 in ICW3 gives write_ICW_2_4, then moves to ICW4 if IC4=1, else to READY.
REQ-023 A write with A0=1 in ICW4 gives write_ICW_2_4 and moves to READY.
REQ-024 In READY, A0=1 gives write_OCW_1.
REQ-025 In READY, A0=0, D4=0, D3=0 gives write_OCW_2.
REQ-026 In READY, A0=0, D4=0, D3=1 gives write_OCW_3.
REQ-027 In WAIT_ICW1, any write other than ICW1 is ignored: no strobe, internal_data_bus unchanged, state unchanged.
REQ-028 In ICW2/ICW3/ICW4, a write with A0=0, D4=0 is ignored the same way.
REQ-029 init_done = 1 only in READY. An ICW1 write in READY restarts the sequence, and init_done drops in the strobe cycle.
REQ-030 read = sampled rd_act & ~sampled wr_act, so read has 1-cycle latency; read_address = registered address while read=1, else holds.
REQ-031 If RD and WR are both active, the write is processed and read stays 0.

Reset
REQ-032 When reset=1, immediately: state=WAIT_ICW1, SNGL=1, IC4=0, all strobes=0, read=0, read_address=0, internal_data_bus=8'h00, init_done=0, and sampled wr_act/rd_act=0.
REQ-033 A write in progress when reset asserts is discarded; a write still active when reset releases completes normally when WR rises.

Verification
REQ-034 After reset, write A0=0 0x13, then A0=1 0x08, then A0=1 0x03 -> strobes write_ICW_1, write_ICW_2_4, write_ICW_2_4; init_done=1 after the third; internal_data_bus=0x03.
REQ-035 Write A0=0 0x11, then A0=1 0x20, 0x04, 0x01 -> ICW3 path: three write_ICW_2_4 pulses; init_done rises only after 0x01.
REQ-036 In READY, write A0=1 0xFE, A0=0 0x20, A0=0 0x0B -> write_OCW_1, write_OCW_2, write_OCW_3 in order; each pulse is 1 cycle wide and 2 edges after WR_n rise.
REQ-037 After reset, write A0=1 0x55 -> no strobe; internal_data_bus=0x00; state remains WAIT_ICW1.
REQ-038 Assert RD_n=0 with A0=1, then assert WR_n=0 during the read, then release both -> read=1 with read_address=1 until WR_n falls, then read=0; one write strobe follows.
REQ-039 Assert reset while WR_n is low mid-sequence (in ICW2) -> all outputs return to reset values at once; after release, an A0=1 write produces no strobe.

Source files
------------

// File: rtl/pic_bus_control.sv
// rtl/pic_bus_control.sv - 8259-style CPU bus front end: write capture, ICW/OCW command decode, read tracking.
module pic_bus_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       read_enable_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_ICW_1,
  output logic       write_ICW_2_4,
  output logic       write_OCW_1,
  output logic       write_OCW_2,
  output logic       write_OCW_3,
  output logic       read,
  output logic       read_address,
  output logic       init_done
);

  typedef enum logic [2:0] {
    WAIT_ICW1,
    ICW2,
    ICW3,
    ICW4,
    READY
  } icw_state_t;

  icw_state_t state;

  logic       wr_act;
  logic       rd_act;
  logic       wr_act_q;
  logic       wr_done;
  logic       cap_addr;
  logic [7:0] cap_data;
  logic       sngl;
  logic       ic4;
  logic       is_icw1;

  assign wr_act  = ~chip_select_n & ~write_enable_n;
  assign rd_act  = ~chip_select_n & ~read_enable_n;
  assign is_icw1 = ~cap_addr & cap_data[4];

  // wr_done marks the edge where the sampled write level fell; the command acts one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_act_q     <= 1'b0;
      wr_done      <= 1'b0;
      cap_addr     <= 1'b0;
      cap_data     <= 8'h00;
      read         <= 1'b0;
      read_address <= 1'b0;
    end else begin
      wr_act_q <= wr_act;
      wr_done  <= wr_act_q & ~wr_act;
      if (wr_act) begin
        cap_addr <= address;
        cap_data <= data_bus_in;
      end
      read <= rd_act & ~wr_act;
      if (rd_act & ~wr_act)
        read_address <= address;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= WAIT_ICW1;
      sngl              <= 1'b1;
      ic4               <= 1'b0;
      internal_data_bus <= 8'h00;
      write_ICW_1       <= 1'b0;
      write_ICW_2_4     <= 1'b0;
      write_OCW_1       <= 1'b0;
      write_OCW_2       <= 1'b0;
      write_OCW_3       <= 1'b0;
      init_done         <= 1'b0;
    end else begin
      write_ICW_1   <= 1'b0;
      write_ICW_2_4 <= 1'b0;
      write_OCW_1   <= 1'b0;
      write_OCW_2   <= 1'b0;
      write_OCW_3   <= 1'b0;
      if (wr_done) begin
        // ICW1 is recognised in every state and always restarts initialisation.
        if (is_icw1) begin
          write_ICW_1       <= 1'b1;
          internal_data_bus <= cap_data;
          sngl              <= cap_data[1];
          ic4               <= cap_data[0];
          state             <= ICW2;
          init_done         <= 1'b0;
        end else begin
          case (state)
            ICW2: begin
              if (cap_addr) begin
                write_ICW_2_4     <= 1'b1;
                internal_data_bus <= cap_data;
                if (!sngl) begin
                  state <= ICW3;
                end else if (ic4) begin
                  state <= ICW4;
                end else begin
                  state     <= READY;
                  init_done <= 1'b1;
                end
              end
            end
            ICW3: begin
              if (cap_addr) begin
                write_ICW_2_4     <= 1'b1;
                internal_data_bus <= cap_data;
                if (ic4) begin
                  state <= ICW4;
                end else begin
                  state     <= READY;
                  init_done <= 1'b1;
                end
              end
            end
            ICW4: begin
              if (cap_addr) begin
                write_ICW_2_4     <= 1'b1;
                internal_data_bus <= cap_data;
                state             <= READY;
                init_done         <= 1'b1;
              end
            end
            READY: begin
              internal_data_bus <= cap_data;
              if (cap_addr)
                write_OCW_1 <= 1'b1;
              else if (cap_data[3])
                write_OCW_3 <= 1'b1;
              else
                write_OCW_2 <= 1'b1;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pic_bus_control.sv
// tb/tb_pic_bus_control.sv - Bench for pic_bus_control: directed vector table, bus corner cases, random writes vs. a transaction model.
module tb_pic_bus_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n, rd_n, wr_n, addr;
  logic [7:0] din;
  logic [7:0] internal_data_bus;
  logic       write_ICW_1, write_ICW_2_4, write_OCW_1, write_OCW_2, write_OCW_3;
  logic       read, read_address, init_done;
  logic [4:0] stb;

  int tests = 0;
  int fails = 0;

  // Transaction-level model: phase 0=waiting ICW1, 1..3 = expecting ICW2..ICW4, 4=ready.
  int         m_st;
  logic       m_sngl, m_ic4;
  logic [7:0] m_idb;

  typedef struct {
    logic       a0;
    logic [7:0] d;
    int         code;
    logic       init;
    logic [7:0] idb;
  } vec_t;

  vec_t vecs[14];

  pic_bus_control dut (
    .clk               (clk),
    .reset             (reset),
    .chip_select_n     (cs_n),
    .read_enable_n     (rd_n),
    .write_enable_n    (wr_n),
    .address           (addr),
    .data_bus_in       (din),
    .internal_data_bus (internal_data_bus),
    .write_ICW_1       (write_ICW_1),
    .write_ICW_2_4     (write_ICW_2_4),
    .write_OCW_1       (write_OCW_1),
    .write_OCW_2       (write_OCW_2),
    .write_OCW_3       (write_OCW_3),
    .read              (read),
    .read_address      (read_address),
    .init_done         (init_done)
  );

  assign stb = {write_ICW_1, write_ICW_2_4, write_OCW_1, write_OCW_2, write_OCW_3};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // code: 0 none, 1 ICW1, 2 ICW2-4, 3 OCW1, 4 OCW2, 5 OCW3
  function automatic logic [4:0] code_vec(input int c);
    code_vec = (c == 0) ? 5'd0 : 5'(5'b1 << (5 - c));
  endfunction

  task automatic model_reset();
    m_st = 0; m_sngl = 1'b1; m_ic4 = 1'b0; m_idb = 8'h00;
  endtask

  task automatic model_write(input logic a0, input logic [7:0] d, output int code);
    code = 0;
    if (!a0 && d[4]) begin
      code = 1; m_sngl = d[1]; m_ic4 = d[0]; m_st = 1;
    end else if (m_st == 4) begin
      code = a0 ? 3 : (d[3] ? 5 : 4);
    end else if (m_st != 0 && a0) begin
      code = 2;
      if (m_st == 1 && !m_sngl) m_st = 2;
      else if (m_st <= 2 && m_ic4) m_st = 3;
      else m_st = 4;
    end
    if (code != 0) m_idb = d;
  endtask

  task automatic bus_write(input logic a0, input logic [7:0] d, input int hold, input int ecode,
                           input logic [7:0] eidb, input logic einit, input string name);
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; addr = a0; din = d;
    repeat (hold) @(posedge clk);
    #1;
    cs_n = 1'b1; wr_n = 1'b1; din = 8'($urandom); addr = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk({name, " early"}, stb, 0);
    @(posedge clk); #1;
    chk({name, " strobe"}, stb, code_vec(ecode));
    chk({name, " idb"}, internal_data_bus, eidb);
    chk({name, " init"}, init_done, einit);
    @(posedge clk); #1;
    chk({name, " width"}, stb, 0);
  endtask

  task automatic mw(input logic a0, input logic [7:0] d, input int hold, input string name);
    int c;
    model_write(a0, d, c);
    bus_write(a0, d, hold, c, m_idb, (m_st == 4), name);
  endtask

  initial begin
    int c;
    int nstb;
    logic       ra0;
    logic [7:0] rd8;

    vecs[0]  = '{a0:1'b1, d:8'h55, code:0, init:1'b0, idb:8'h00};
    vecs[1]  = '{a0:1'b0, d:8'h13, code:1, init:1'b0, idb:8'h13};
    vecs[2]  = '{a0:1'b1, d:8'h08, code:2, init:1'b0, idb:8'h08};
    vecs[3]  = '{a0:1'b1, d:8'h03, code:2, init:1'b1, idb:8'h03};
    vecs[4]  = '{a0:1'b1, d:8'hFE, code:3, init:1'b1, idb:8'hFE};
    vecs[5]  = '{a0:1'b0, d:8'h20, code:4, init:1'b1, idb:8'h20};
    vecs[6]  = '{a0:1'b0, d:8'h0B, code:5, init:1'b1, idb:8'h0B};
    vecs[7]  = '{a0:1'b0, d:8'h11, code:1, init:1'b0, idb:8'h11};
    vecs[8]  = '{a0:1'b0, d:8'h00, code:0, init:1'b0, idb:8'h11};
    vecs[9]  = '{a0:1'b1, d:8'h20, code:2, init:1'b0, idb:8'h20};
    vecs[10] = '{a0:1'b1, d:8'h04, code:2, init:1'b0, idb:8'h04};
    vecs[11] = '{a0:1'b1, d:8'h01, code:2, init:1'b1, idb:8'h01};
    vecs[12] = '{a0:1'b0, d:8'h1A, code:1, init:1'b0, idb:8'h1A};
    vecs[13] = '{a0:1'b1, d:8'h30, code:2, init:1'b1, idb:8'h30};

    reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = 1'b0; din = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset strobes", stb, 0);
    chk("reset idb", internal_data_bus, 8'h00);
    chk("reset init", init_done, 0);
    chk("reset read", read, 0);
    chk("reset read_address", read_address, 0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      model_write(vecs[i].a0, vecs[i].d, c);
      bus_write(vecs[i].a0, vecs[i].d, 1 + (i % 3), vecs[i].code, vecs[i].idb, vecs[i].init,
                $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 2; i++) begin
      ra0 = i[0];
      @(posedge clk); #1;
      cs_n = 1'b0; rd_n = 1'b0; addr = ra0;
      @(posedge clk); #1;
      chk("read level", read, 1);
      chk("read addr", read_address, ra0);
      cs_n = 1'b1; rd_n = 1'b1; addr = ~ra0;
      @(posedge clk); #1;
      chk("read drop", read, 0);
      chk("read addr hold", read_address, ra0);
    end

    @(posedge clk); #1;
    cs_n = 1'b0; rd_n = 1'b0; addr = 1'b1;
    @(posedge clk); #1;
    chk("overlap read", read, 1);
    chk("overlap read addr", read_address, 1);
    wr_n = 1'b0; din = 8'h5A;
    @(posedge clk); #1;
    chk("overlap read off", read, 0);
    chk("overlap addr held", read_address, 1);
    @(posedge clk); #1;
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    model_write(1'b1, 8'h5A, c);
    nstb = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (stb != 5'd0) begin
        nstb++;
        chk("overlap strobe kind", stb, code_vec(c));
      end
      chk("overlap read low", read, 0);
    end
    chk("overlap strobe count", nstb, 1);
    chk("overlap idb", internal_data_bus, 8'h5A);

    mw(1'b0, 8'h13, 1, "pre-reset icw1");
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h08;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async reset strobes", stb, 0);
    chk("async reset idb", internal_data_bus, 8'h00);
    chk("async reset init", init_done, 0);
    chk("async reset read", read, 0);
    chk("async reset read_address", read_address, 0);
    model_reset();
    @(posedge clk); #1;
    cs_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mw(1'b1, 8'h08, 2, "post-reset a0=1");

    @(posedge clk); #1;
    reset = 1'b1; cs_n = 1'b0; wr_n = 1'b0; addr = 1'b0; din = 8'h13;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cs_n = 1'b1; wr_n = 1'b1;
    model_write(1'b0, 8'h13, c);
    @(posedge clk); #1;
    chk("span-reset early", stb, 0);
    @(posedge clk); #1;
    chk("span-reset strobe", stb, code_vec(c));
    chk("span-reset idb", internal_data_bus, 8'h13);

    for (int i = 0; i < 60; i++) begin
      ra0 = 1'($urandom_range(0, 1));
      rd8 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ra0 = 1'b0; rd8[4] = 1'b1;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      mw(ra0, rd8, $urandom_range(1, 3), $sformatf("rand%0d a0=%0d d=%02h", i, ra0, rd8));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
